// File: rtl/chunked_addsub_if.sv
// Handshake and data bundle for chunked_addsub: operand/request side plus result side.
interface chunked_addsub_if #(
    parameter int unsigned N = 16
) ();
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         c_i;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] s;
    logic         c_o;
    logic         ovf;
    logic         busy;

    modport master (
        output in_valid, x, y, c_i, sub, out_ready,
        input  in_ready, out_valid, s, c_o, ovf, busy
    );

    modport slave (
        input  in_valid, x, y, c_i, sub, out_ready,
        output in_ready, out_valid, s, c_o, ovf, busy
    );
endinterface

// File: rtl/chunked_addsub.sv
// Multi-cycle N-bit adder/subtractor: one K-bit carry-chained slice, LS chunk first,
// M = N/K compute cycles per operation, valid/ready on both sides.
module chunked_addsub #(
    parameter int unsigned N = 16,
    parameter int unsigned K = 4
) (
    input logic             clk,
    input logic             rst,
    chunked_addsub_if.slave bus
);
    localparam int unsigned M  = N / K;
    localparam int unsigned CW = (M > 1) ? $clog2(M) : 1;
    localparam logic [CW-1:0] LastCnt = CW'(M - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e        r_state;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic [N-1:0]  r_s;
    logic          r_carry;
    logic          r_c_o;
    logic          r_ovf;

    int unsigned   w_base;
    logic [K-1:0]  w_a_chunk;
    logic [K-1:0]  w_b_chunk;
    logic [K:0]    w_sum;
    logic [K-1:0]  w_r;
    logic          w_cout;
    logic          w_msb_cin;

    always_comb begin
        w_base    = 32'(r_cnt) * K;
        w_a_chunk = r_a[w_base +: K];
        w_b_chunk = r_b[w_base +: K];
        w_sum     = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{K{1'b0}}, r_carry};
        w_r       = w_sum[K-1:0];
        w_cout    = w_sum[K];
        // Carry into the chunk MSB recovered from the sum bit; works for K == 1 as well.
        w_msb_cin = w_a_chunk[K-1] ^ w_b_chunk[K-1] ^ w_r[K-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_s     <= '0;
            r_c_o   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.x;
                        r_b     <= bus.sub ? ~bus.y : bus.y;
                        r_carry <= bus.c_i;
                        r_cnt   <= '0;
                        r_state <= StRun;
                    end
                end
                StRun: begin
                    r_s[w_base +: K] <= w_r;
                    r_carry          <= w_cout;
                    if (r_cnt == LastCnt) begin
                        r_c_o   <= w_cout;
                        r_ovf   <= w_msb_cin ^ w_cout;
                        r_state <= StDone;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == StIdle);
    assign bus.busy      = (r_state != StIdle);
    assign bus.out_valid = (r_state == StDone);
    assign bus.s         = r_s;
    assign bus.c_o       = r_c_o;
    assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_chunked_addsub.sv
// Self-checking bench for chunked_addsub: directed N=16/K=4 sequence plus a randomized
// sweep over (8,8), (8,1) and (32,8) against a plain-arithmetic reference.
module tb_chunked_addsub;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    chunked_addsub_if #(.N(16)) bus16 ();
    chunked_addsub_if #(.N(8))  bus88 ();
    chunked_addsub_if #(.N(8))  bus81 ();
    chunked_addsub_if #(.N(32)) bus32 ();

    chunked_addsub #(.N(16), .K(4)) u16  (.clk(clk), .rst(rst), .bus(bus16.slave));
    chunked_addsub #(.N(8),  .K(8)) u88  (.clk(clk), .rst(rst), .bus(bus88.slave));
    chunked_addsub #(.N(8),  .K(1)) u81  (.clk(clk), .rst(rst), .bus(bus81.slave));
    chunked_addsub #(.N(32), .K(8)) u328 (.clk(clk), .rst(rst), .bus(bus32.slave));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: modulo-2^n sum, unsigned carry out, two's-complement overflow from signs.
    function automatic void model(input int n, input logic [31:0] x, input logic [31:0] y,
                                  input logic ci, input logic sb, output logic [31:0] s,
                                  output logic co, output logic ovf);
        logic [63:0] mask;
        logic [63:0] bb;
        logic [63:0] sum;
        mask = (64'd1 << n) - 64'd1;
        bb   = sb ? (~{32'd0, y}) & mask : {32'd0, y};
        sum  = {32'd0, x} + bb + {63'd0, ci};
        s    = sum[31:0] & mask[31:0];
        co   = sum[n];
        ovf  = (x[n-1] == bb[n-1]) && (s[n-1] != x[n-1]);
    endfunction

    task automatic start16(input logic [15:0] x, input logic [15:0] y, input logic ci,
                           input logic sb);
        check("in_ready_before_accept", {63'd0, bus16.in_ready}, 64'd1);
        bus16.x        = x;
        bus16.y        = y;
        bus16.c_i      = ci;
        bus16.sub      = sb;
        bus16.in_valid = 1'b1;
        step();
        bus16.in_valid = 1'b0;
    endtask

    task automatic wait16(output int lat, input bit scramble);
        lat = -1;
        for (int k = 1; k <= 50; k++) begin
            if (scramble) begin
                bus16.x        = 16'($urandom);
                bus16.y        = 16'($urandom);
                bus16.c_i      = 1'($urandom);
                bus16.sub      = 1'($urandom);
                bus16.in_valid = 1'($urandom);
            end
            step();
            if (bus16.out_valid) begin
                lat = k;
                break;
            end
        end
        bus16.in_valid = 1'b0;
    endtask

    task automatic op16(input string tag, input logic [15:0] x, input logic [15:0] y,
                        input logic ci, input logic sb, input logic [15:0] es,
                        input logic eco, input logic eovf);
        int lat;
        start16(x, y, ci, sb);
        wait16(lat, 1'b0);
        check({tag, "_latency"}, 64'(lat), 64'd4);
        check({tag, "_s"}, {48'd0, bus16.s}, {48'd0, es});
        check({tag, "_c_o"}, {63'd0, bus16.c_o}, {63'd0, eco});
        check({tag, "_ovf"}, {63'd0, bus16.ovf}, {63'd0, eovf});
        check({tag, "_in_ready_in_done"}, {63'd0, bus16.in_ready}, 64'd0);
        bus16.out_ready = 1'b1;
        step();
        bus16.out_ready = 1'b0;
        check({tag, "_in_ready_after"}, {63'd0, bus16.in_ready}, 64'd1);
        check({tag, "_out_valid_after"}, {63'd0, bus16.out_valid}, 64'd0);
    endtask

    task automatic sweep_round();
        logic [31:0] x[3], y[3], es[3], os[3];
        logic        ci[3], sb[3], eco[3], eovf[3], oco[3], oovf[3];
        int          lat[3];
        int          n[3] = '{8, 8, 32};
        int          m[3] = '{1, 8, 4};
        for (int i = 0; i < 3; i++) begin
            x[i]   = $urandom;
            y[i]   = $urandom;
            if (n[i] == 8) begin
                x[i] = x[i] & 32'hFF;
                y[i] = y[i] & 32'hFF;
            end
            ci[i]  = 1'($urandom);
            sb[i]  = 1'($urandom);
            lat[i] = -1;
            model(n[i], x[i], y[i], ci[i], sb[i], es[i], eco[i], eovf[i]);
        end
        bus88.x = x[0][7:0];  bus88.y = y[0][7:0];  bus88.c_i = ci[0]; bus88.sub = sb[0];
        bus81.x = x[1][7:0];  bus81.y = y[1][7:0];  bus81.c_i = ci[1]; bus81.sub = sb[1];
        bus32.x = x[2];       bus32.y = y[2];       bus32.c_i = ci[2]; bus32.sub = sb[2];
        bus88.in_valid = 1'b1;
        bus81.in_valid = 1'b1;
        bus32.in_valid = 1'b1;
        step();
        bus88.in_valid = 1'b0;
        bus81.in_valid = 1'b0;
        bus32.in_valid = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (bus88.out_valid && lat[0] < 0) begin
                lat[0] = k; os[0] = {24'd0, bus88.s}; oco[0] = bus88.c_o; oovf[0] = bus88.ovf;
            end
            if (bus81.out_valid && lat[1] < 0) begin
                lat[1] = k; os[1] = {24'd0, bus81.s}; oco[1] = bus81.c_o; oovf[1] = bus81.ovf;
            end
            if (bus32.out_valid && lat[2] < 0) begin
                lat[2] = k; os[2] = bus32.s; oco[2] = bus32.c_o; oovf[2] = bus32.ovf;
            end
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("sweep%0d_latency", i), 64'(lat[i]), 64'(m[i]));
            if (lat[i] > 0) begin
                check($sformatf("sweep%0d_s", i), {32'd0, os[i]}, {32'd0, es[i]});
                check($sformatf("sweep%0d_c_o", i), {63'd0, oco[i]}, {63'd0, eco[i]});
                check($sformatf("sweep%0d_ovf", i), {63'd0, oovf[i]}, {63'd0, eovf[i]});
            end
        end
    endtask

    initial begin
        int          lat;
        logic [31:0] rs;
        logic        rco, rovf;
        logic [15:0] rx, ry;
        logic        rci, rsb;

        rst = 1'b1;
        bus16.in_valid = 1'b0; bus16.out_ready = 1'b0;
        bus16.x = '0; bus16.y = '0; bus16.c_i = 1'b0; bus16.sub = 1'b0;
        bus88.in_valid = 1'b0; bus88.out_ready = 1'b1;
        bus88.x = '0; bus88.y = '0; bus88.c_i = 1'b0; bus88.sub = 1'b0;
        bus81.in_valid = 1'b0; bus81.out_ready = 1'b1;
        bus81.x = '0; bus81.y = '0; bus81.c_i = 1'b0; bus81.sub = 1'b0;
        bus32.in_valid = 1'b0; bus32.out_ready = 1'b1;
        bus32.x = '0; bus32.y = '0; bus32.c_i = 1'b0; bus32.sub = 1'b0;
        step();
        step();
        rst = 1'b0;

        check("reset_in_ready", {63'd0, bus16.in_ready}, 64'd1);
        check("reset_out_valid", {63'd0, bus16.out_valid}, 64'd0);
        check("reset_busy", {63'd0, bus16.busy}, 64'd0);
        check("reset_s", {48'd0, bus16.s}, 64'd0);
        check("reset_c_o", {63'd0, bus16.c_o}, 64'd0);
        check("reset_ovf", {63'd0, bus16.ovf}, 64'd0);

        op16("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        op16("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        op16("add_wrap_ci", 16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0);
        op16("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        op16("sub_borrow", 16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);

        // Backpressure: inputs scrambled during RUN, out_ready held low in DONE.
        start16(16'h00FF, 16'h0F01, 1'b0, 1'b0);
        wait16(lat, 1'b1);
        check("bp_latency", 64'(lat), 64'd4);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_s_%0d", k), {48'd0, bus16.s}, 64'h1000);
            check($sformatf("bp_c_o_%0d", k), {63'd0, bus16.c_o}, 64'd0);
            check($sformatf("bp_ovf_%0d", k), {63'd0, bus16.ovf}, 64'd0);
            check($sformatf("bp_in_ready_%0d", k), {63'd0, bus16.in_ready}, 64'd0);
            check($sformatf("bp_out_valid_%0d", k), {63'd0, bus16.out_valid}, 64'd1);
            step();
        end
        bus16.out_ready = 1'b1;
        step();
        bus16.out_ready = 1'b0;
        check("bp_release_in_ready", {63'd0, bus16.in_ready}, 64'd1);
        op16("back_to_back", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);

        // Reset while the counter sits at chunk 2.
        start16(16'hABCD, 16'h1234, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_in_ready", {63'd0, bus16.in_ready}, 64'd1);
        check("midrst_out_valid", {63'd0, bus16.out_valid}, 64'd0);
        check("midrst_s", {48'd0, bus16.s}, 64'd0);
        check("midrst_c_o", {63'd0, bus16.c_o}, 64'd0);
        check("midrst_ovf", {63'd0, bus16.ovf}, 64'd0);
        op16("after_rst", 16'hF00F, 16'h1FF1, 1'b1, 1'b0, 16'h1001, 1'b1, 1'b0);

        for (int r = 0; r < 20; r++) begin
            rx  = 16'($urandom);
            ry  = 16'($urandom);
            rci = 1'($urandom);
            rsb = 1'($urandom);
            model(16, {16'd0, rx}, {16'd0, ry}, rci, rsb, rs, rco, rovf);
            op16($sformatf("rand16_%0d", r), rx, ry, rci, rsb, rs[15:0], rco, rovf);
        end

        for (int r = 0; r < 10; r++) begin
            sweep_round();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/chunked_addsub.md
Name: chunked_addsub

Overview:
- Multi-cycle N-bit adder/subtractor.
- Adds or subtracts two operands K bits per clock, least-significant chunk first, through one K-bit carry-chained adder slice.
- Uses valid/ready handshakes on both sides.
- Used where a full N-bit ripple chain would miss timing or cost too much area, for example datapath accumulators and address arithmetic in the basic arithmetic library.

Parameters:
- N, 16, operand and result width in bits; must be a multiple of K and at least 1.
- K, 4, chunk width in bits processed per cycle; 1 <= K <= N.
- M is derived, not a parameter: M = N/K, the number of compute cycles per operation.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operands and mode present.
- in_ready  out  1  block can accept an operation.
- x  in  N  operand A.
- y  in  N  operand B.
- c_i  in  1  carry-in to chunk 0.
- sub  in  1  0 = add, 1 = subtract (y is inverted).
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- s  out  N  result.
- c_o  out  1  carry out of bit N-1.
- ovf  out  1  signed overflow: carry into bit N-1 XOR carry out of bit N-1.
- busy  out  1  high in RUN or DONE.

Behaviour:
- States: IDLE, RUN, DONE.
- Combinational outputs: in_ready = (state==IDLE); busy = !in_ready; out_valid = (state==DONE).
- Reset (rst high at an edge):
  - state becomes IDLE; chunk counter = 0.
  - s = 0, c_o = 0, ovf = 0, so out_valid = 0 and in_ready = 1.
  - Applies in any state, including mid-RUN and DONE; any in-flight or unconsumed result is discarded.
- Accept:
  - Occurs at an edge where in_valid && in_ready.
  - Latch a = x, b = (sub ? ~y : y), carry = c_i. Clear counter. Go to RUN.
  - c_i is used verbatim in both modes. Plain subtract x-y therefore requires sub=1, c_i=1; sub=1, c_i=0 gives x-y-1.
- RUN, each edge with counter i:
  - {cout, r} = a[iK+K-1:iK] + b[iK+K-1:iK] + carry.
  - Write r into s[iK+K-1:iK]; carry <= cout.
  - On the last chunk (i == M-1): also capture the carry into bit N-1 for ovf, set c_o = cout, go to DONE.
  - Otherwise increment the counter.
- Latency: with accept at edge E, out_valid rises after edge E+M. Example: N=16, K=4 gives 4 cycles.
- Partial s bits are visible during RUN and are not valid; consumers must qualify s with out_valid.
- DONE:
  - s, c_o and ovf hold stable while out_valid is high.
  - Leave on an edge with out_ready high: go to IDLE, and in_ready rises the following cycle.
  - out_ready is ignored in IDLE and RUN.
- Inputs x, y, sub, c_i and in_valid are ignored outside IDLE; changing them during RUN has no effect.
- No overlap: in_ready and out_valid are never high together. Maximum throughput is one operation per M+2 cycles when out_ready is held high.
- Arithmetic is modulo 2^N; c_o is the unsigned carry. For subtract, c_o=1 means no borrow.
- K == N: M = 1 and the counter is degenerate (width at least 1, always 0). The same state sequence applies.
- K == 1: fully bit-serial, M = N.

Test Plan:
- N=16, K=4, add: x=0x1234, y=0x4321, c_i=0, sub=0 -> out_valid 4 cycles after accept; s=0x5555, c_o=0, ovf=0.
- Carry ripple across every chunk and wrap: x=0xFFFF, y=0x0001, c_i=0, sub=0 -> s=0x0000, c_o=1, ovf=0. Same x and y with c_i=1 -> s=0x0001, c_o=1.
- Subtract and signed overflow:
  - x=0x8000, y=0x0001, sub=1, c_i=1 -> s=0x7FFF, c_o=1, ovf=1.
  - x=0x0003, y=0x0005, sub=1, c_i=1 -> s=0xFFFE, c_o=0, ovf=0.
- Backpressure and input isolation:
  - Hold out_ready=0 for 5 cycles in DONE -> s/c_o/ovf constant, in_ready=0 throughout.
  - Toggle x/y during RUN -> result unchanged.
  - Raise out_ready -> IDLE next cycle; a back-to-back second operation completes correctly.
- Reset mid-operation: assert rst at RUN chunk 2 -> next cycle in_ready=1, out_valid=0, s=0, c_o=0, ovf=0. A new operation then completes normally.
- Parameter sweep, random operands against a reference model, including sub and c_i variations:
  - (N=8, K=8): result after 1 cycle.
  - (N=8, K=1): result after 8 cycles.
  - (N=32, K=8): result after 4 cycles.
